// File: rtl/dircc_counter_send_handler.sv
// ---------------------------------------------------------------------------
// dircc_counter_send_handler
//
// Sits after the counter RTS stage. When the registered rts_ready flag is
// seen for the device the state store is presenting, this block latches that
// device's index and count. It sends one counter packet on the network port
// using a valid/ready handshake. It then writes the device state back with
// rts cleared and the count advanced (saturating). After that it waits one
// guard cycle so the registered upstream flag can catch up with the
// writeback.
//
// Ports
//   clk            in   clock
//   reset_n        in   asynchronous, active-low reset
//   rts_ready_i    in   registered ready-to-send from the RTS stage
//   dev_idx_i      in   device index presented by the state store
//   state_count_i  in   count field of the presented device state
//   pkt_valid_o    out  packet valid to the network port
//   pkt_ready_i    in   network port accepts the packet
//   pkt_src_o      out  source device index of the packet
//   pkt_data_o     out  payload: zero-extended captured count
//   state_we_o     out  one-cycle state store write strobe
//   state_idx_o    out  device index being written
//   state_count_o  out  new count value (saturating increment)
//   state_rts_o    out  new rts flag, always 0
//   busy_o         out  high whenever the FSM is not IDLE
//   sent_total_o   out  packets sent since reset, wraps at 2^32
// ---------------------------------------------------------------------------
module dircc_counter_send_handler #(
    parameter int DEV_IDX_W = 4,
    parameter int COUNT_W   = 16,
    parameter int PAYLOAD_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rts_ready_i,
    input  logic [DEV_IDX_W-1:0] dev_idx_i,
    input  logic [COUNT_W-1:0]   state_count_i,
    output logic                 pkt_valid_o,
    input  logic                 pkt_ready_i,
    output logic [DEV_IDX_W-1:0] pkt_src_o,
    output logic [PAYLOAD_W-1:0] pkt_data_o,
    output logic                 state_we_o,
    output logic [DEV_IDX_W-1:0] state_idx_o,
    output logic [COUNT_W-1:0]   state_count_o,
    output logic                 state_rts_o,
    output logic                 busy_o,
    output logic [31:0]          sent_total_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WRBACK,
        ST_GUARD
    } state_t;

    state_t               r_state;
    logic [DEV_IDX_W-1:0] r_cap_idx;
    logic [COUNT_W-1:0]   r_cap_count;
    logic                 r_pkt_valid;
    logic [DEV_IDX_W-1:0] r_pkt_src;
    logic [PAYLOAD_W-1:0] r_pkt_data;
    logic                 r_state_we;
    logic [DEV_IDX_W-1:0] r_state_idx;
    logic [COUNT_W-1:0]   r_state_count;
    logic                 r_busy;
    logic [31:0]          r_sent_total;

    // Saturating increment of the captured count. An all-ones count stays
    // all-ones, so the count cannot wrap back to zero.
    logic [COUNT_W-1:0]   w_count_next;
    assign w_count_next = (r_cap_count == {COUNT_W{1'b1}})
                        ? r_cap_count
                        : r_cap_count + {{(COUNT_W-1){1'b0}}, 1'b1};

    // NOTE: asynchronous reset clears every register, including the capture
    // registers. A packet or writeback in progress is dropped without a
    // partial write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_cap_idx     <= '0;
            r_cap_count   <= '0;
            r_pkt_valid   <= 1'b0;
            r_pkt_src     <= '0;
            r_pkt_data    <= '0;
            r_state_we    <= 1'b0;
            r_state_idx   <= '0;
            r_state_count <= '0;
            r_busy        <= 1'b0;
            r_sent_total  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout. Every register
            // updates from the values held before this edge, so the order
            // of the statements below does not matter.
            case (r_state)
                ST_IDLE: begin
                    if (rts_ready_i) begin
                        r_cap_idx   <= dev_idx_i;
                        r_cap_count <= state_count_i;
                        r_pkt_valid <= 1'b1;
                        r_pkt_src   <= dev_idx_i;
                        r_pkt_data  <= PAYLOAD_W'(state_count_i);
                        r_busy      <= 1'b1;
                        r_state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Valid is high for the whole of SEND. The packet
                    // registers hold until the port accepts.
                    if (pkt_ready_i) begin
                        r_pkt_valid   <= 1'b0;
                        r_pkt_src     <= '0;
                        r_pkt_data    <= '0;
                        r_state_we    <= 1'b1;
                        r_state_idx   <= r_cap_idx;
                        r_state_count <= w_count_next;
                        r_sent_total  <= r_sent_total + 32'd1;
                        r_state       <= ST_WRBACK;
                    end
                end
                ST_WRBACK: begin
                    r_state_we    <= 1'b0;
                    r_state_idx   <= '0;
                    r_state_count <= '0;
                    r_state       <= ST_GUARD;
                end
                ST_GUARD: begin
                    // rts_ready_i is still registered from before the
                    // writeback, so it is deliberately not looked at here.
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pkt_valid_o   = r_pkt_valid;
    assign pkt_src_o     = r_pkt_src;
    assign pkt_data_o    = r_pkt_data;
    assign state_we_o    = r_state_we;
    assign state_idx_o   = r_state_idx;
    assign state_count_o = r_state_count;
    assign state_rts_o   = 1'b0;
    assign busy_o        = r_busy;
    assign sent_total_o  = r_sent_total;

endmodule
